// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for pipe_stage_skid.
// Provides the NOP fill bit, level_t, and a saturating add for counters.
package pipe_pkg;

  localparam logic PIPE_NOP_BIT = 1'b0;

  typedef logic [1:0] level_t;

  function automatic logic [31:0] sat_add(
    input logic [31:0] cnt,
    input logic [31:0] inc,
    input logic [31:0] max_v
  );
    if (inc > max_v - cnt) return max_v;
    return cnt + inc;
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// pipe_stage_entry: valid+data register with load and clear.
// Clear wins over load; an invalid entry always holds NOP_VALUE.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{PIPE_NOP_BIT}}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid_q,
  output logic [DATA_W-1:0] data_q
);

  // Hold, reload or kill the entry; empty slots carry NOP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VALUE;
    end else if (clear) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VALUE;
    end else if (load) begin
      valid_q <= valid_d;
      data_q  <= valid_d ? data_d : NOP_VALUE;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with flush-to-NOP.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer version.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{PIPE_NOP_BIT}},
  parameter int unsigned CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

  logic              accept;
  logic              m_valid;
  logic              m_load;
  logic              m_src_v;
  logic [DATA_W-1:0] m_src_d;
  level_t            held;

  assign accept    = in_valid && in_ready;
  assign m_load    = !m_valid || out_ready;
  assign out_valid = m_valid;
  assign level     = held;

`ifdef PIPE_STAGE_SKID_EN
  logic              s_valid;
  logic [DATA_W-1:0] s_data;

  assign in_ready = !s_valid;
  assign m_src_v  = s_valid || accept;
  assign m_src_d  = s_valid ? s_data : in_data;
  assign held     = {1'b0, m_valid} + {1'b0, s_valid};

  pipe_stage_entry #(
    .DATA_W    (DATA_W),
    .NOP_VALUE (NOP_VALUE)
  ) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept && !m_load),
    .clear   (flush || (m_load && s_valid)),
    .valid_d (1'b1),
    .data_d  (in_data),
    .valid_q (s_valid),
    .data_q  (s_data)
  );
`else
  assign in_ready = !m_valid || out_ready;
  assign m_src_v  = accept;
  assign m_src_d  = in_data;
  assign held     = {1'b0, m_valid};
`endif

  pipe_stage_entry #(
    .DATA_W    (DATA_W),
    .NOP_VALUE (NOP_VALUE)
  ) u_main (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (m_load),
    .clear   (flush),
    .valid_d (m_src_v),
    .data_d  (m_src_d),
    .valid_q (m_valid),
    .data_q  (out_data)
  );

  // Count live entries killed by flush, sticking at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flush_count <= '0;
    end else if (flush) begin
      flush_count <= CNT_W'(sat_add(32'(flush_count),
                                    32'(held), CNT_MAX));
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks against a FIFO model.
// Works with or without PIPE_STAGE_SKID_EN defined.
module tb_pipe_stage_skid;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [7:0] NOP = 8'hE7;
  localparam int CAP = SKID ? 2 : 1;
  localparam int CMAX = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] level;
  logic [1:0] flush_count;

  int total = 0;
  int bad = 0;

  pipe_stage_skid #(
    .DATA_W    (8),
    .NOP_VALUE (NOP),
    .CNT_W     (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .flush_count (flush_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of capacity CAP plus a saturating counter.
  logic [7:0] q[$];
  int  mcnt = 0;
  bit  m_acc;
  bit  m_con;

  function automatic bit m_rdy();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      mcnt = 0;
    end else begin
      m_acc = in_valid && m_rdy();
      m_con = (q.size() > 0) && out_ready;
      if (flush) begin
        mcnt = mcnt + q.size();
        if (mcnt > CMAX) mcnt = CMAX;
        q.delete();
      end else begin
        if (m_con) void'(q.pop_front());
        if (m_acc) q.push_back(in_data);
        if (q.size() > CAP) begin
          total++;
          bad++;
          $display("FAIL model_overflow: got %0d want <=%0d",
                   q.size(), CAP);
        end
      end
    end
  end

  // Every falling edge: DUT outputs must match the model.
  always @(negedge clock) begin
    chk("c_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("c_data", 32'(out_data), 32'((q.size() > 0) ? q[0] : NOP));
    chk("c_level", 32'(level), 32'(q.size()));
    chk("c_ready", 32'(in_ready), 32'(m_rdy()));
    chk("c_fcnt", 32'(flush_count), 32'(mcnt));
  end

  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clock);
    #1;
  endtask

  int fs;
  int e;

  initial begin
    #12 reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'(NOP));
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_fcnt", 32'(flush_count), 32'd0);

    cyc(1'b1, 8'h11, 1'b1, 1'b0);
    chk("s_11", 32'(out_data), 32'h11);
    chk("s_lv1", 32'(level), 32'd1);
    cyc(1'b1, 8'h22, 1'b1, 1'b0);
    chk("s_22", 32'(out_data), 32'h22);
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    chk("s_33", 32'(out_data), 32'h33);
    chk("s_lv3", 32'(level), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s_idle_v", 32'(out_valid), 32'd0);
    chk("s_idle_d", 32'(out_data), 32'(NOP));

    if (SKID) begin
      cyc(1'b1, 8'hA1, 1'b0, 1'b0);
      chk("k_lv1", 32'(level), 32'd1);
      cyc(1'b1, 8'hA2, 1'b0, 1'b0);
      chk("k_lv2", 32'(level), 32'd2);
      chk("k_rdy0", 32'(in_ready), 32'd0);
      cyc(1'b1, 8'hA3, 1'b0, 1'b0);
      chk("k_hold", 32'(out_data), 32'hA1);
      chk("k_lv2b", 32'(level), 32'd2);
      cyc(1'b1, 8'hA3, 1'b1, 1'b0);
      chk("k_A2", 32'(out_data), 32'hA2);
      chk("k_lv1b", 32'(level), 32'd1);
      cyc(1'b1, 8'hA3, 1'b1, 1'b0);
      chk("k_A3", 32'(out_data), 32'hA3);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("k_end", 32'(out_valid), 32'd0);
    end else begin
      cyc(1'b1, 8'hA1, 1'b0, 1'b0);
      chk("n_A1", 32'(out_data), 32'hA1);
      chk("n_rdy0", 32'(in_ready), 32'd0);
      cyc(1'b1, 8'hA2, 1'b1, 1'b0);
      chk("n_A2", 32'(out_data), 32'hA2);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("n_end", 32'(out_valid), 32'd0);
    end

    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    if (SKID) cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    cyc(1'b1, 8'hB0, 1'b0, 1'b1);
    chk("f_valid", 32'(out_valid), 32'd0);
    chk("f_data", 32'(out_data), 32'(NOP));
    chk("f_level", 32'(level), 32'd0);
    chk("f_fcnt", 32'(flush_count), SKID ? 32'd2 : 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("f_noB0", 32'(out_valid), 32'd0);

    fs = SKID ? 2 : 1;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 8'hC0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      e = (fs + k + 1 > 3) ? 3 : fs + k + 1;
      chk("sat", 32'(flush_count), 32'(e));
    end

    cyc(1'b1, 8'hD1, 1'b0, 1'b0);
    if (SKID) cyc(1'b1, 8'hD2, 1'b0, 1'b0);
    chk("r_pre", 32'(level), SKID ? 32'd2 : 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("r_valid", 32'(out_valid), 32'd0);
    chk("r_data", 32'(out_data), 32'(NOP));
    chk("r_level", 32'(level), 32'd0);
    chk("r_fcnt", 32'(flush_count), 32'd0);
    chk("r_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 15) == 0));
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush to a NOP encoding, and an optional two-entry skid buffer. It generalises the fixed 32-bit IF/ID latch so that any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can be built from one block, for any payload width. Back-pressure replaces the ad-hoc enable: upstream stalls via `in_ready`, downstream stalls via `out_ready`. The block also reports occupancy and keeps a count of valid instructions killed by flushes.

## Interface
- `DATA_W`, 32: payload width in bits.
- `NOP_VALUE`, `{DATA_W{1'b0}}`: word driven on `out_data` whenever `out_valid`=0, and inserted by flush.
- `CNT_W`, 16: width of `flush_count`.
- `clock`  in  1  rising-edge clock, the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  stage accepts `in_data` this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `flush`  in  1  synchronous kill of all held entries.
- `out_valid`  out  1  `out_data` holds a live instruction.
- `out_ready`  in  1  downstream consumes `out_data` this cycle.
- `out_data`  out  DATA_W  stage payload; equals `NOP_VALUE` when `out_valid`=0.
- `level`  out  2  entries held (0..2; max 1 without skid).
- `flush_count`  out  CNT_W  saturating count of valid entries discarded by `flush`.

## Operation
- Accept: `in_valid && in_ready`. Consume: `out_valid && out_ready`.
- Storage: main entry (drives `out_*`) and, with skid enabled, a skid entry.
- Main entry loads when it is empty or consumed this cycle. Source is the skid entry if that entry is valid; otherwise the accepted input; otherwise `NOP_VALUE` with valid=0.
- An accepted input that cannot enter main (main held, not consumed) goes to skid. Skid is emptied when main loads from it.
- Flush has priority over every other event. On the next edge both entries become invalid, `out_data`=`NOP_VALUE`, and any input accepted in the same cycle is discarded. `in_ready` may be 1 during flush; the handshake completes and the data is dropped.
- `flush_count` adds the number of valid entries killed (0, 1 or 2) on each flush edge. It saturates at all-ones and never wraps.
- Simultaneous accept and consume with skid empty: main replaces its data and `level` is unchanged.
- Consume with skid full and an input pending: main takes the skid entry and `in_ready` was 0, so nothing is accepted.

## Timing
- Reset (async assert, sync-clean deassert internally not required): `out_valid`=0, `out_data`=`NOP_VALUE`, `level`=0, `flush_count`=0, `in_ready`=1.
- Latency: 1 cycle from accept to `out_valid`. Throughput: 1 per cycle with `out_ready` held high.
- Skid mode: `in_ready` = skid entry empty, a registered output with no combinational path from `out_ready`.
- Non-skid mode: `in_ready` = `!out_valid || out_ready`, a combinational path from `out_ready`.
- Reset asserted mid-transfer: all entries lost immediately, with no `flush_count` update.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: two-entry skid buffer, registered `in_ready`, `level` reaches 2, and one stall cycle of upstream slack.
- `PIPE_STAGE_SKID_EN` undefined: single entry only, combinational `in_ready`, and `level` bit 1 is tied to 0. All other behaviour is identical.

## Structure
- Shared package `pipe_pkg`: default `NOP_VALUE` constant, `level_t` (2-bit) typedef, and a `flush_count` saturate helper function.
- One sub-module, `pipe_stage_entry`, is natural. It is a valid+data register with load, clear and NOP-on-clear, and is instantiated as the main entry and, under the macro, the skid entry.

## Test plan
- Reset, then idle: `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1, `level`=0, `flush_count`=0.
- Stream 0x11,0x22,0x33 with `out_ready`=1: outputs appear one cycle later, back-to-back, and `level` stays 1.
- Skid mode: send 0xA1,0xA2 with `out_ready`=0.
  - Expected: `level`=2 and `in_ready`=0 with 0xA3 held.
  - Then raise `out_ready`: outputs are 0xA1, 0xA2, 0xA3 in order, with none lost or duplicated.
- Fill to `level`=2, then assert `flush` while `in_valid`=1 (0xB0).
  - Expected next cycle: `out_valid`=0, `out_data`=`NOP_VALUE`, `level`=0, `flush_count`=2.
  - 0xB0 is never output.
- Preload `flush_count` near all-ones via repeated flushes (use `CNT_W`=2): after reaching 3, further flushes keep it at 3.
- Assert `reset_n`=0 mid-cycle with `level`=2: outputs go to reset values before the next clock edge.
